uart_tx_queue_ctrl: RTL

Memory-mapped transmit scheduler between the memory controller and `UART_duplex`. Core stores to the UART TX address are buffered in a small FIFO instead of stalling or being lost while the UART is busy. Bytes are issued to the UART one at a time with the `tx_send` / `uart_busy` handshake. A 32-bit status word is returned to the bus for polling.

---
 rtl/uart_tx_queue_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue_ctrl.sv
// Transmit scheduler: buffers bus stores to the UART TX address in a small FIFO
// and feeds the UART one byte at a time, with a pollable 32-bit status word.
module uart_tx_queue_ctrl #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        ovf_clr,
  input  logic        tx_pause,
  input  logic        uart_busy,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  output logic [31:0] status_rddata,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // UART handshake: tx_send is a one-cycle pulse with tx_data stable from that
  // cycle until the next pop; the UART answers by raising uart_busy for the
  // duration of the frame. If busy never rises within BUSY_TIMEOUT cycles the
  // byte is treated as sent and the scheduler moves on without retrying.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   to_cnt;
  logic            overflow;
  logic            full, empty;
  logic            push_ok, pop;
  logic            to_clr, to_inc;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = wr_en & ~full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_busy && !tx_pause) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        to_clr    = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      to_cnt   <= '0;
      overflow <= 1'b0;
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state   <= state_nxt;
      tx_send <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (to_clr) begin
        to_cnt <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + TW'(1);
      end
      // A dropped push in the same cycle as a clear keeps the flag set.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    status_rddata         = 32'h0;
    status_rddata[0]      = full;
    status_rddata[1]      = empty;
    status_rddata[2]      = overflow;
    status_rddata[3]      = (state != IDLE) | ~empty;
    status_rddata[8 +: CW] = count;
  end

  assign state_dbg = state;

endmodule
